seq_checker: RTL

- Downstream consumer and scoreboard for the 32-bit recurrence stream from seq_generator: s[n] = s[n-2] + s[n-3], mod 2^32.
- Accepts samples over a valid/ready handshake and primes its history with the first three accepted values.
- Checks every later sample against the recurrence and reports mismatches, expected/received values and a match count.
- Sits between the sequence source and the status/CSR logic.

---
 rtl/seq_pkg.sv | 30 +++
 rtl/seq_hist3.sv | 37 +++
 rtl/seq_checker.sv | 135 +++++++++++++
 3 files changed

// File: rtl/seq_pkg.sv
// Shared types and constants for the recurrence stream s[n] = s[n-2] + s[n-3].
// Used by seq_checker and seq_hist3. seq_generator should also adopt seq_data_t.
package seq_pkg;

  typedef logic [31:0] seq_data_t;

  typedef enum logic [2:0] {
    PRIME0 = 3'd0,
    PRIME1 = 3'd1,
    PRIME2 = 3'd2,
    CHECK  = 3'd3,
    HALT   = 3'd4
  } chk_state_e;

  localparam seq_data_t SEQ_SEED0 = 32'd1;
  localparam seq_data_t SEQ_SEED1 = 32'd0;
  localparam seq_data_t SEQ_SEED2 = 32'd1;

  // Seed expected while priming in the given state.
  function automatic seq_data_t seed_of(input chk_state_e st);
    seq_data_t seed;
    case (st)
      PRIME0:  seed = SEQ_SEED0;
      PRIME1:  seed = SEQ_SEED1;
      default: seed = SEQ_SEED2;
    endcase
    return seed;
  endfunction

endpackage

// File: rtl/seq_hist3.sv
// Three-entry sample history (h0 oldest, h2 newest) with the h0+h1 predictor.
module seq_hist3 #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_clear,
  input  logic              i_shift,
  input  logic [DATA_W-1:0] i_data,
  output logic [DATA_W-1:0] o_sum
);

  logic [DATA_W-1:0] r_h0;
  logic [DATA_W-1:0] r_h1;
  logic [DATA_W-1:0] r_h2;

  // Shift each accepted sample in; a clear wipes the whole window.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_h0 <= '0;
      r_h1 <= '0;
      r_h2 <= '0;
    end else if (i_clear) begin
      r_h0 <= '0;
      r_h1 <= '0;
      r_h2 <= '0;
    end else if (i_shift) begin
      r_h0 <= r_h1;
      r_h1 <= r_h2;
      r_h2 <= i_data;
    end
  end

  // Prediction for the next sample; wraps mod 2^DATA_W.
  assign o_sum = r_h0 + r_h1;

endmodule

// File: rtl/seq_checker.sv
// Scoreboard for the s[n] = s[n-2] + s[n-3] stream. Primes on three beats, then checks
// every beat, reporting mismatches and a saturating match count.
// Optional: define SEQ_CHECKER_SEED_CHECK_EN to also compare priming beats against seeds 1,0,1.
module seq_checker
  import seq_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned STOP_ON_ERR = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] seq_i,
  input  logic              seq_valid_i,
  output logic              seq_ready_o,
  input  logic              clear_i,
  output logic              err_o,
  output logic              err_sticky_o,
  output logic [DATA_W-1:0] exp_o,
  output logic [DATA_W-1:0] got_o,
  output logic [CNT_W-1:0]  match_cnt_o,
  output logic              primed_o
);

  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  chk_state_e        r_state;
  chk_state_e        w_state_nxt;
  logic              r_ready;
  logic              r_err;
  logic              r_sticky;
  logic [DATA_W-1:0] r_exp;
  logic [DATA_W-1:0] r_got;
  logic [CNT_W-1:0]  r_cnt;

  logic              w_accept;
  logic              w_check_en;
  logic [DATA_W-1:0] w_sum;
  logic [DATA_W-1:0] w_exp;
  logic              w_mismatch;
  logic              w_match;

  // A clear drops any beat presented in the same cycle.
  assign w_accept = seq_valid_i && r_ready && !clear_i;

  seq_hist3 #(
    .DATA_W(DATA_W)
  ) u_hist (
    .clk    (clk),
    .reset  (reset),
    .i_clear(clear_i),
    .i_shift(w_accept),
    .i_data (seq_i),
    .o_sum  (w_sum)
  );

`ifdef SEQ_CHECKER_SEED_CHECK_EN
  // HALT never accepts, so every accepted beat is either a seed or a recurrence check.
  assign w_check_en = 1'b1;
  assign w_exp      = (r_state == CHECK) ? w_sum : DATA_W'(seed_of(r_state));
`else
  assign w_check_en = (r_state == CHECK);
  assign w_exp      = w_sum;
`endif

  assign w_mismatch = w_accept && w_check_en && (seq_i != w_exp);
  assign w_match    = w_accept && (r_state == CHECK) && (seq_i == w_sum);

  // Next state: clear wins, priming advances per beat, a mismatch may halt.
  always_comb begin
    w_state_nxt = r_state;
    if (clear_i) begin
      w_state_nxt = PRIME0;
    end else if (w_accept) begin
      if (w_mismatch && (STOP_ON_ERR != 0)) begin
        w_state_nxt = HALT;
      end else begin
        unique case (r_state)
          PRIME0:  w_state_nxt = PRIME1;
          PRIME1:  w_state_nxt = PRIME2;
          PRIME2:  w_state_nxt = CHECK;
          default: w_state_nxt = r_state;
        endcase
      end
    end
  end

  // State register and registered ready (low only in HALT).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= PRIME0;
      r_ready <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_ready <= (w_state_nxt != HALT);
    end
  end

  // Status: one-cycle error pulse, sticky flag, mismatch capture, saturating match count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_err    <= 1'b0;
      r_sticky <= 1'b0;
      r_exp    <= '0;
      r_got    <= '0;
      r_cnt    <= '0;
    end else if (clear_i) begin
      r_err    <= 1'b0;
      r_sticky <= 1'b0;
      r_exp    <= '0;
      r_got    <= '0;
      r_cnt    <= '0;
    end else begin
      r_err <= w_mismatch;
      if (w_mismatch) begin
        r_sticky <= 1'b1;
        r_exp    <= w_exp;
        r_got    <= seq_i;
      end
      if (w_match && (r_cnt != CntMax)) begin
        r_cnt <= r_cnt + CntOne;
      end
    end
  end

  assign seq_ready_o  = r_ready;
  assign err_o        = r_err;
  assign err_sticky_o = r_sticky;
  assign exp_o        = r_exp;
  assign got_o        = r_got;
  assign match_cnt_o  = r_cnt;
  assign primed_o     = (r_state == CHECK) || (r_state == HALT);

endmodule
